run_sequencer: RTL and testbench
================================

# run_sequencer

Synthesizable job sequencer that drives the FullSystem processor core the way the system testbench does by hand. It queues 16-bit input operands and applies each one to the core's `Input` while holding the core in reset. It then releases reset, counts cycles until the core's `finalOutput` goes nonzero, and returns the result and cycle count over a valid/ready port. It sits between a host-side job source and one `FullSystemSchm` instance, and owns that instance's `Reset` and `Input` pins.

## Interface
- `WIDTH`, 16, data width of operands and results.
- `FIFO_DEPTH`, 4, job queue depth; must be a power of 2, ≥2.
- `RESET_CYCLES`, 2, number of cycles `core_reset` is held after a new operand is loaded; must be ≥1.
- `MAX_CYCLES`, 65535, RUN-cycle limit before a timeout result is produced; must be ≥1 and fit in `CNT_W`.
- `CNT_W`, 16, width of the cycle counter and `res_cycles`.

- `CLK` in 1: single clock; all logic is on the rising edge.
- `Reset` in 1: asynchronous, active-high; clears all state, including the FIFO.
- `job_valid` in 1: host offers an operand.
- `job_data` in WIDTH: operand value.
- `job_ready` out 1: queue not full; a push occurs when `job_valid` and `job_ready` are both high at a clock edge.
- `core_reset` out WIDTH-independent 1: drives the core's `Reset`; registered.
- `core_input` out WIDTH: drives the core's `Input`; registered.
- `core_output` in WIDTH: the core's `finalOutput`.
- `res_valid` out 1: result available.
- `res_ready` in 1: host accepts the result.
- `res_data` out WIDTH: captured `finalOutput`, or 0 on timeout.
- `res_cycles` out CNT_W: number of RUN cycles including the detecting cycle, or `MAX_CYCLES` on timeout.
- `res_timeout` out 1: the result was produced by timeout.
- `busy` out 1: high in any state other than IDLE.

## Operation
- Job FIFO: circular buffer with `FIFO_DEPTH` entries, with pointers one bit wider than the address.
  - Push and pop may occur in the same cycle.
  - No push is possible when the FIFO is full, because `job_ready` is low.
  - A push into an empty FIFO cannot be popped in the same edge; the earliest pop is the next edge.
- FSM states: IDLE, LOAD, RUN, DONE.
  - IDLE: `core_reset`=1. If the FIFO is non-empty, pop the head into `core_input`, clear the hold counter, and go to LOAD.
  - LOAD: `core_reset`=1. The hold counter increments each cycle. After `RESET_CYCLES` cycles in LOAD, clear the cycle counter, set `core_reset`<=0, and go to RUN.
  - RUN: `core_reset`=0, cycle counter `cnt` increments each edge.
    - If `core_output`≠0 at the edge: `res_data`<=`core_output`, `res_cycles`<=`cnt`+1, `res_timeout`<=0, `res_valid`<=1, `core_reset`<=1, go to DONE.
    - Else if `cnt`+1==`MAX_CYCLES`: `res_data`<=0, `res_cycles`<=`MAX_CYCLES`, `res_timeout`<=1, `res_valid`<=1, `core_reset`<=1, go to DONE.
  - DONE: `core_reset`=1, and result outputs are held stable. On `res_valid`&&`res_ready`: `res_valid`<=0, go to IDLE.
- Results come out in the same order as operands were pushed. Exactly one result is produced per operand.
- `core_input` changes only on the IDLE→LOAD edge, while `core_reset` is high, so the core never sees an operand change while it is running.
- The zero test covers all WIDTH bits of `core_output`. A legitimate zero result is indistinguishable from "not finished"; such a job resolves as a timeout.

## Timing
- Reset values:
  - `core_reset`=1, `core_input`=0, `res_valid`=0, `res_data`=0, `res_cycles`=0, `res_timeout`=0, `busy`=0.
  - `job_ready`=1 (FIFO empty); state IDLE.
- Push accepted at edge T into an empty, idle sequencer:
  - pop and move to LOAD at edge T+1;
  - `core_reset` falls at edge T+1+`RESET_CYCLES`.
- If the core's output is nonzero on the k-th RUN edge: `res_valid` rises after that edge and `res_cycles`=k.
- Result handshake at edge H: the next job pops at edge H+1 at the earliest. The core therefore sees `core_reset` high for at least `RESET_CYCLES`+2 cycles between jobs.
- While `res_ready` is low in DONE, no pop occurs, `core_reset` stays 1, and pushes continue until the FIFO is full.
- `Reset` asserted mid-operation, in any state: the FIFO is emptied, any in-flight job and any unaccepted result are discarded, and all outputs take their reset values immediately (asynchronously).

## Test plan
- Push 5040; the core model returns 0x1234 on the 37th RUN cycle → `res_data`=0x1234, `res_cycles`=37, `res_timeout`=0, and `core_reset` was high for exactly 2 cycles after `core_input`=5040.
- Push 5040, 2310, 4095 back-to-back with `res_ready`=1 → three results in order. `core_input` changes only while `core_reset`=1, and each reset gap is ≥4 cycles.
- Set `MAX_CYCLES`=100; the core output stays 0 → `res_timeout`=1, `res_data`=0, `res_cycles`=100, then the next job starts.
- Hold `res_ready`=0 while pushing 6 operands → `job_ready` falls once 4 are queued beyond the active job. `res_valid` stays high with stable data, and `core_reset` stays 1.
- Simultaneous push and pop with the FIFO at depth 3 → depth stays 3 and data order is preserved across pointer wrap-around.
- Assert `Reset` on the 10th RUN cycle with 2 jobs queued → all outputs return to their reset values. After release, no result appears until a new push.

Source files
------------

// File: rtl/run_sequencer.sv
// run_sequencer: queues operands, runs each through the core under reset control,
// and returns the first nonzero core output with its RUN cycle count.
module run_sequencer #(
  parameter int WIDTH        = 16,
  parameter int FIFO_DEPTH   = 4,
  parameter int RESET_CYCLES = 2,
  parameter int MAX_CYCLES   = 65535,
  parameter int CNT_W        = 16
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             job_valid,
  input  logic [WIDTH-1:0] job_data,
  output logic             job_ready,
  output logic             core_reset,
  output logic [WIDTH-1:0] core_input,
  input  logic [WIDTH-1:0] core_output,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic [CNT_W-1:0] res_cycles,
  output logic             res_timeout,
  output logic             busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int HW = $clog2(RESET_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
  state_t stateQ, stateD;
  logic [WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW:0] wrPtr, rdPtr;
  logic [HW-1:0] hold;
  logic [CNT_W-1:0] cnt, cntInc;
  logic empty, full, push, pop, holdDone, hit, expire;
  assign empty = wrPtr == rdPtr;
  assign full = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
  assign job_ready = !full;
  assign push = job_valid && !full;
  always_ff @(posedge CLK or posedge Reset)
    if (Reset) stateQ <= IDLE;
    else stateQ <= stateD;
  always_comb begin
    stateD = stateQ;
    case (stateQ)
      IDLE: stateD = empty ? IDLE : LOAD;
      LOAD: stateD = holdDone ? RUN : LOAD;
      RUN:  stateD = (hit || expire) ? DONE : RUN;
      DONE: stateD = res_ready ? IDLE : DONE;
      default: stateD = IDLE;
    endcase
  end
  always_comb begin
    pop = stateQ == IDLE && !empty;
    holdDone = hold == HW'(RESET_CYCLES - 1);
    cntInc = cnt + 1'b1;
    hit = core_output != '0;
    expire = cntInc == CNT_W'(MAX_CYCLES);
    busy = stateQ != IDLE;
  end
  always_ff @(posedge CLK)
    if (push) mem[wrPtr[AW-1:0]] <= job_data;
  // core_reset tracks the next state so it drops exactly on the LOAD->RUN edge
  always_ff @(posedge CLK or posedge Reset)
    if (Reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      hold <= '0;
      cnt <= '0;
      core_reset <= 1'b1;
      core_input <= '0;
      res_valid <= 1'b0;
      res_data <= '0;
      res_cycles <= '0;
      res_timeout <= 1'b0;
    end else begin
      core_reset <= stateD != RUN;
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop) begin
        rdPtr <= rdPtr + 1'b1;
        core_input <= mem[rdPtr[AW-1:0]];
        hold <= '0;
      end
      if (stateQ == LOAD) begin
        hold <= hold + 1'b1;
        cnt <= '0;
      end
      if (stateQ == RUN) begin
        cnt <= cntInc;
        if (hit || expire) begin
          res_valid <= 1'b1;
          res_data <= hit ? core_output : '0;
          res_cycles <= cntInc;
          res_timeout <= !hit;
        end
      end
      if (stateQ == DONE && res_ready) res_valid <= 1'b0;
    end
endmodule

// File: tb/tb_run_sequencer.sv
// tb_run_sequencer: scoreboard bench with a behavioural core model driving core_output.
module tb_run_sequencer;
  typedef struct {logic [15:0] d; logic [15:0] c; logic t;} exp_t;
  logic CLK = 0, Reset = 0, job_valid = 0, res_ready = 0;
  logic [15:0] job_data = 0, core_input, core_output, res_data, res_cycles;
  logic job_ready, core_reset, res_valid, res_timeout, busy;
  exp_t sb[$];
  int nTests = 0, nFail = 0;
  logic [15:0] coreCnt, prevIn;
  logic prevBusy = 0, prevRst = 1, seenRun = 0;
  int hiCnt = 0, loadCnt = 0;

  run_sequencer #(.WIDTH(16), .FIFO_DEPTH(4), .RESET_CYCLES(2), .MAX_CYCLES(100), .CNT_W(16)) dut (
    .CLK(CLK), .Reset(Reset), .job_valid(job_valid), .job_data(job_data), .job_ready(job_ready),
    .core_reset(core_reset), .core_input(core_input), .core_output(core_output),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_cycles(res_cycles),
    .res_timeout(res_timeout), .busy(busy));

  always #5 CLK = ~CLK;

  // Core model: result appears after a per-operand latency of RUN cycles and then holds.
  function automatic logic [15:0] coreModel(input logic [15:0] x, input logic [15:0] c);
    logic [15:0] lat, val;
    case (x)
      16'd5040: begin lat = 16'd37; val = 16'h1234; end
      16'd2310: begin lat = 16'd12; val = 16'hBEEF; end
      16'd4095: begin lat = 16'd5;  val = 16'h0FFF; end
      16'd0:    begin lat = 16'd1;  val = 16'h0000; end
      default:  begin lat = {12'd0, x[3:0]} + 16'd1; val = x ^ 16'h5A5A; end
    endcase
    return (c + 16'd1 >= lat) ? val : 16'd0;
  endfunction

  always @(posedge CLK) coreCnt <= core_reset ? 16'd0 : coreCnt + 16'd1;
  assign core_output = core_reset ? 16'd0 : coreModel(core_input, coreCnt);

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge CLK)
    if (!Reset && res_valid && res_ready) begin
      if (sb.size() == 0) check("unexpected_result", res_valid, 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        check("res_data", res_data, e.d);
        check("res_cycles", res_cycles, e.c);
        check("res_timeout", res_timeout, e.t);
      end
    end

  always @(negedge CLK) begin
    if (Reset) begin
      hiCnt = 0;
      loadCnt = 0;
      seenRun = 0;
    end else begin
      if (core_input !== prevIn && !core_reset) check("input_while_running", core_reset, 1);
      if (busy && !prevBusy) loadCnt = 0;
      if (core_reset) begin
        hiCnt++;
        loadCnt++;
      end else if (prevRst) begin
        if (seenRun) check("reset_gap_ge4", hiCnt >= 4, 1);
        check("load_hold_cycles", loadCnt, 2);
        seenRun = 1;
        hiCnt = 0;
      end
    end
    prevIn = core_input;
    prevBusy = busy;
    prevRst = core_reset;
  end

  task automatic pushJob(input logic [15:0] d, input logic [15:0] ed, input logic [15:0] ec, input logic et);
    bit acc = 0;
    job_valid = 1;
    job_data = d;
    for (int i = 0; i < 2000 && !acc; i++) begin
      acc = job_ready;
      @(posedge CLK); #1;
    end
    job_valid = 0;
    if (acc) sb.push_back('{ed, ec, et});
    else check("push_timeout", acc, 1);
  endtask

  task automatic waitDrain(input int bound);
    int i = 0;
    while (i < bound && (sb.size() != 0 || busy)) begin
      @(posedge CLK); #1;
      i++;
    end
    check("drain", sb.size(), 0);
  endtask

  task automatic checkResetValues(input string tag);
    check({tag, "_core_reset"}, core_reset, 1);
    check({tag, "_core_input"}, core_input, 0);
    check({tag, "_res_valid"}, res_valid, 0);
    check({tag, "_res_data"}, res_data, 0);
    check({tag, "_res_cycles"}, res_cycles, 0);
    check({tag, "_res_timeout"}, res_timeout, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_job_ready"}, job_ready, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, tests run %0d", nTests);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] d0, c0;
    #1 Reset = 1;
    #2 checkResetValues("rst");
    repeat (2) @(posedge CLK);
    #1 Reset = 0;
    res_ready = 1;
    // single job, 37-cycle latency
    pushJob(16'd5040, 16'h1234, 16'd37, 1'b0);
    waitDrain(500);
    // back-to-back jobs
    pushJob(16'd5040, 16'h1234, 16'd37, 1'b0);
    pushJob(16'd2310, 16'hBEEF, 16'd12, 1'b0);
    pushJob(16'd4095, 16'h0FFF, 16'd5, 1'b0);
    waitDrain(1000);
    // timeout then a normal job
    pushJob(16'd0, 16'h0000, 16'd100, 1'b1);
    pushJob(16'h1001, 16'h4A5B, 16'd2, 1'b0);
    waitDrain(1000);
    // stalled result with a full queue
    res_ready = 0;
    pushJob(16'h1001, 16'h4A5B, 16'd2, 1'b0);
    pushJob(16'h2002, 16'h7A58, 16'd3, 1'b0);
    pushJob(16'h3003, 16'h6A59, 16'd4, 1'b0);
    pushJob(16'h4004, 16'h1A5E, 16'd5, 1'b0);
    pushJob(16'h5005, 16'h0A5F, 16'd6, 1'b0);
    check("job_ready_full", job_ready, 0);
    for (int i = 0; i < 100 && !res_valid; i++) begin
      @(posedge CLK); #1;
    end
    check("stall_valid", res_valid, 1);
    check("stall_data", res_data, 16'h4A5B);
    d0 = res_data;
    c0 = res_cycles;
    job_valid = 1;
    job_data = 16'h6006;
    repeat (20) begin
      @(posedge CLK); #1;
      check("stall_hold_valid", res_valid, 1);
      check("stall_hold_data", res_data, d0);
      check("stall_hold_cycles", res_cycles, c0);
      check("stall_core_reset", core_reset, 1);
      check("stall_job_ready", job_ready, 0);
    end
    res_ready = 1;
    pushJob(16'h6006, 16'h3A5C, 16'd7, 1'b0);
    waitDrain(1000);
    // streaming with pushes and pops on the same edge, wrapping the pointers
    pushJob(16'h1001, 16'h4A5B, 16'd2, 1'b0);
    pushJob(16'h2002, 16'h7A58, 16'd3, 1'b0);
    pushJob(16'h3003, 16'h6A59, 16'd4, 1'b0);
    pushJob(16'h4004, 16'h1A5E, 16'd5, 1'b0);
    pushJob(16'h5005, 16'h0A5F, 16'd6, 1'b0);
    pushJob(16'h6006, 16'h3A5C, 16'd7, 1'b0);
    pushJob(16'h7007, 16'h2A5D, 16'd8, 1'b0);
    pushJob(16'h8008, 16'hDA52, 16'd9, 1'b0);
    pushJob(16'd4095, 16'h0FFF, 16'd5, 1'b0);
    waitDrain(2000);
    // asynchronous reset mid-run with jobs queued
    pushJob(16'd5040, 16'h1234, 16'd37, 1'b0);
    pushJob(16'h1001, 16'h4A5B, 16'd2, 1'b0);
    pushJob(16'h2002, 16'h7A58, 16'd3, 1'b0);
    for (int i = 0; i < 200 && core_reset; i++) begin
      @(posedge CLK); #1;
    end
    check("run_entered", core_reset, 0);
    repeat (9) @(posedge CLK);
    #1 Reset = 1;
    #1 checkResetValues("midrst");
    sb.delete();
    repeat (2) @(posedge CLK);
    #1 Reset = 0;
    repeat (30) begin
      @(posedge CLK); #1;
      check("post_rst_valid", res_valid, 0);
      check("post_rst_busy", busy, 0);
    end
    pushJob(16'h3003, 16'h6A59, 16'd4, 1'b0);
    waitDrain(500);
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end
endmodule
